pool2d_stream: RTL and testbench



---
 rtl/pool2d_pkg.sv | 35 +++
 rtl/pool2d_lane.sv | 81 ++++++++
 rtl/pool2d_stream.sv | 164 ++++++++++++++++
 tb/tb_pool2d_stream.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool2d_pkg.sv
// pool2d_pkg: shared sizing helpers for the streaming pooling engine.
//   out_dim     - number of whole windows along one axis (floor)
//   clog2_min1  - ceil(log2(v)) clamped to at least 1, for counter widths
//   log2_exact  - ceil(log2(v)) without clamping, used as a shift amount
//   is_pow2     - true when v is a positive power of two
// The POOL2D_CH macro selects channel c out of a packed pixel bus.
// Optional feature macro: POOL2D_AVG_EN (used by pool2d_stream / pool2d_lane).
`ifndef POOL2D_CH
`define POOL2D_CH(bus, c, w) bus[(c)*(w) +: (w)]
`endif

package pool2d_pkg;

  function automatic int out_dim(input int img, input int pool);
    return img / pool;
  endfunction

  function automatic int log2_exact(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int clog2_min1(input int v);
    int r;
    r = log2_exact(v);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pool2d_lane.sv
// pool2d_lane: per-channel window accumulator.
// Holds one accumulator entry per output column (OUT_W entries). On each
// written beat the entry at ox is loaded (first pixel of a window) or
// updated with max(entry, pixel); result is the value that the entry takes
// on this beat, reduced to DATA_W, so the parent can register it when the
// beat completes a window.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   pix         channel sample of the current beat
//   ox          output-column index selecting the accumulator entry
//   wr          write the entry this cycle (accepted beat inside a window)
//   first       beat is the first pixel of its window (load instead of merge)
//   avg         (POOL2D_AVG_EN only) window is in average mode
//   result      merged value of this beat, DATA_W bits
// Optional feature macro: POOL2D_AVG_EN adds a summing path; entries are
// then ACC_W = DATA_W + SH bits wide and result = sum >>> SH.
module pool2d_lane
  import pool2d_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
`ifdef POOL2D_AVG_EN
  parameter int SH     = 2,
`endif
  parameter int SIGNED = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_W-1:0]                   pix,
  input  logic [clog2_min1(OUT_W)-1:0]        ox,
  input  logic                                wr,
  input  logic                                first,
`ifdef POOL2D_AVG_EN
  input  logic                                avg,
`endif
  output logic [DATA_W-1:0]                   result
);

  logic [ACC_W-1:0] acc [OUT_W];
  logic [ACC_W-1:0] entry;
  logic [ACC_W-1:0] pix_ext;
  logic [ACC_W-1:0] next_val;
  logic             greater;
`ifdef POOL2D_AVG_EN
  logic [ACC_W-1:0] shifted;
`endif

  always_comb begin
    entry = acc[ox];
    // Extend the sample to accumulator width so max and sum share one
    // representation; signed data is sign-extended.
    pix_ext = (SIGNED != 0) ? ACC_W'($signed(pix)) : ACC_W'(pix);
    greater = (SIGNED != 0) ? ($signed(pix_ext) > $signed(entry))
                            : (pix_ext > entry);
    if (first) begin
      next_val = pix_ext;
    end else begin
      next_val = greater ? pix_ext : entry;
    end
`ifdef POOL2D_AVG_EN
    if (avg && !first) begin
      next_val = entry + pix_ext;
    end
    shifted = (SIGNED != 0) ? ACC_W'($signed(next_val) >>> SH)
                            : (next_val >> SH);
    result  = avg ? shifted[DATA_W-1:0] : next_val[DATA_W-1:0];
`else
    result  = next_val[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (wr) begin
      acc[ox] <= next_val;
    end
  end

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming non-overlapping POOL_W x POOL_H max pooling.
// One pixel (all channels packed) per accepted beat in raster order; one
// pooled pixel per completed window on the output handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/valid/last  input pixel stream; in_ready is the back-pressure
//   out_data/valid/last output pooled stream; out_ready from downstream
//   frame_err           sticky: in_last disagreed with the raster counters
//   avg_mode            (POOL2D_AVG_EN only) average instead of max, sampled
//                       at the first pixel of each window
// Handshake: a beat moves when valid && ready on the same rising edge.
//   in_ready = !out_valid || out_ready, so a completing beat is never
//   accepted while a pooled pixel is stalled; out_data/out_last hold while
//   out_valid && !out_ready.
// Optional feature macro: POOL2D_AVG_EN.
module pool2d_stream
  import pool2d_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 32,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int POOL_W   = 2,
  parameter int POOL_H   = 2,
  parameter int SIGNED   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
`ifdef POOL2D_AVG_EN
  input  logic                         avg_mode,
`endif
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         frame_err
);

  localparam int OUT_W = out_dim(IMG_W, POOL_W);
  localparam int OUT_H = out_dim(IMG_H, POOL_H);
  localparam int CW    = clog2_min1(IMG_W);
  localparam int RW    = clog2_min1(IMG_H);
  localparam int OX_W  = clog2_min1(OUT_W);
`ifdef POOL2D_AVG_EN
  localparam int SH    = log2_exact(POOL_W * POOL_H);
  localparam int ACC_W = DATA_W + SH;

  if (!is_pow2(POOL_W * POOL_H)) begin : g_bad_pool
    $error("pool2d_stream: POOL_W*POOL_H must be a power of two for averaging");
  end
`else
  localparam int ACC_W = DATA_W;
`endif

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  int              col_i;
  int              row_i;
  logic            accept;
  logic            in_win;
  logic            first;
  logic            done;
  logic            last_win;
  logic            at_final;
  logic [OX_W-1:0] ox;
  logic [CHANNELS*DATA_W-1:0] lane_res;
`ifdef POOL2D_AVG_EN
  logic            mode_q [OUT_W];
  logic            eff_avg;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    col_i    = int'(col);
    row_i    = int'(row);
    // Trailing columns/rows that do not fill a whole window are consumed
    // but never touch the accumulators.
    in_win   = (col_i < OUT_W * POOL_W) && (row_i < OUT_H * POOL_H);
    first    = in_win && (col_i % POOL_W == 0) && (row_i % POOL_H == 0);
    done     = in_win && (col_i % POOL_W == POOL_W - 1)
                      && (row_i % POOL_H == POOL_H - 1);
    last_win = (col_i / POOL_W == OUT_W - 1) && (row_i / POOL_H == OUT_H - 1);
    at_final = (col_i == IMG_W - 1) && (row_i == IMG_H - 1);
    ox       = OX_W'(col_i / POOL_W);
  end

`ifdef POOL2D_AVG_EN
  // Windows of different columns interleave row by row, so the mode chosen
  // at each window's first pixel is remembered per output column.
  assign eff_avg = first ? avg_mode : mode_q[ox];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) mode_q[i] <= 1'b0;
    end else if (accept && first) begin
      mode_q[ox] <= avg_mode;
    end
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool2d_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
`ifdef POOL2D_AVG_EN
      .SH     (SH),
`endif
      .SIGNED (SIGNED)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix    (`POOL2D_CH(in_data, c, DATA_W)),
      .ox     (ox),
      .wr     (accept && in_win),
      .first  (first),
`ifdef POOL2D_AVG_EN
      .avg    (eff_avg),
`endif
      .result (`POOL2D_CH(lane_res, c, DATA_W))
    );
  end

  // Raster counters advance on every accepted beat and never resync to
  // in_last; a mismatch only raises the sticky frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      if (in_last != at_final) frame_err <= 1'b1;
      if (col_i == IMG_W - 1) begin
        col <= '0;
        row <= (row_i == IMG_H - 1) ? '0 : RW'(row_i + 1);
      end else begin
        col <= CW'(col_i + 1);
      end
    end
  end

  // A completion in the same cycle as a drain simply replaces the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept && done) begin
      out_data  <= lane_res;
      out_valid <= 1'b1;
      out_last  <= last_win;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: directed bench for pool2d_stream.
// dut   : default parameters (16x16, 32 channels, signed), ramp frames with
//         and without stalls, frame_err and mid-frame reset.
// dut_b : 5x3 frame, 2 channels, signed; dut_c : same, unsigned. Both share
//         one input stream and always-ready outputs.
// With POOL2D_AVG_EN defined, an extra small frame exercises avg_mode.
module tb_pool2d_stream;

  localparam int DW = 16;
  localparam int CH = 32;
  localparam int BW = DW * CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT signals ----------------
  logic [BW-1:0] in_data;
  logic          in_valid, in_ready, in_last;
  logic [BW-1:0] out_data;
  logic          out_valid, out_ready, out_last, frame_err;

  // ---------------- small DUT signals ----------------
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic        b_in_ready, c_in_ready;
  logic [31:0] b_out_data, c_out_data;
  logic        b_out_valid, c_out_valid, b_out_last, c_out_last;
  logic        b_frame_err, c_frame_err;
`ifdef POOL2D_AVG_EN
  logic        avg_mode;
`endif

  int checks = 0;
  int errors = 0;

  pool2d_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
`ifdef POOL2D_AVG_EN
    .avg_mode(1'b0),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_err(frame_err)
  );

  pool2d_stream #(.DATA_W(16), .CHANNELS(2), .IMG_W(5), .IMG_H(3),
                  .POOL_W(2), .POOL_H(2), .SIGNED(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_data), .in_valid(s_valid), .in_ready(b_in_ready), .in_last(s_last),
`ifdef POOL2D_AVG_EN
    .avg_mode(avg_mode),
`endif
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(s_ready),
    .out_last(b_out_last), .frame_err(b_frame_err)
  );

  pool2d_stream #(.DATA_W(16), .CHANNELS(2), .IMG_W(5), .IMG_H(3),
                  .POOL_W(2), .POOL_H(2), .SIGNED(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_data), .in_valid(s_valid), .in_ready(c_in_ready), .in_last(s_last),
`ifdef POOL2D_AVG_EN
    .avg_mode(avg_mode),
`endif
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(s_ready),
    .out_last(c_out_last), .frame_err(c_frame_err)
  );

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [BW+7:0] obs, input logic [BW+7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard (main DUT) ----------------
  logic [BW:0]   exp_q[$];
  bit            scb_en = 1'b1;
  bit            holding = 1'b0;
  logic [BW-1:0] held;
  logic [BW:0]   e_beat;

  always @(negedge clk) begin
    if (rst_n && holding) chk("hold_stable", {out_valid, out_data}, {1'b1, held});
    holding = 1'b0;
    if (rst_n && out_valid && !out_ready) begin
      held    = out_data;
      holding = 1'b1;
    end
    if (rst_n && out_valid && out_ready && scb_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {out_last, out_data}, '1);
      end else begin
        e_beat = exp_q.pop_front();
        chk("out_beat", {out_last, out_data}, e_beat);
      end
    end
  end

  // Small DUT output capture ({last, data}).
  logic [32:0] got_b[$];
  logic [32:0] got_c[$];
  always @(negedge clk) begin
    if (rst_n && b_out_valid) got_b.push_back({b_out_last, b_out_data});
    if (rst_n && c_out_valid) got_c.push_back({c_out_last, c_out_data});
  end

  // ---------------- out_ready driver ----------------
  bit stall_en = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [BW-1:0] ramp_px(input int r, input int c);
    logic [BW-1:0] d;
    for (int ch = 0; ch < CH; ch++) d[ch*DW +: DW] = 16'(r * 16 + c + ch * 256);
    return d;
  endfunction

  task automatic send_px(input logic [BW-1:0] d, input logic last, input bit gaps);
    int waitc;
    if (gaps && $urandom_range(0, 99) < 25) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waitc    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waitc++;
      if (waitc > 1000) begin
        chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_ramp_exp();
    logic [BW:0] e;
    for (int oy = 0; oy < 8; oy++) begin
      for (int ox = 0; ox < 8; ox++) begin
        for (int ch = 0; ch < CH; ch++)
          e[ch*DW +: DW] = 16'((2 * oy + 1) * 16 + 2 * ox + 1 + ch * 256);
        e[BW] = (ox == 7) && (oy == 7);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_ramp(input bit gaps);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        send_px(ramp_px(r, c), (r == 15) && (c == 15), gaps);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Channel 0 sample table for the 5x3 frames; channel 1 = sample + 10.
  logic [15:0] px_tab [2][15];

  task automatic send_small(input int t);
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1;
      s_data  = {16'(px_tab[t][i] + 16'd10), px_tab[t][i]};
      s_last  = (i == 14);
`ifdef POOL2D_AVG_EN
      avg_mode = (t == 1) && ((i % 5) < 2);
`endif
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [32:0] eb [4];
  logic [32:0] ec [4];

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_ready  = 1'b1;
`ifdef POOL2D_AVG_EN
    avg_mode = 1'b0;
`endif
    px_tab[0] = '{16'hFFFB, 16'hFFFE, 16'hFFFF, 16'h0003, 16'h7FFF,
                  16'hFFF9, 16'hFFFD, 16'h0000, 16'hFFFC, 16'h7FFF,
                  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    px_tab[1] = '{16'h0004, 16'h0008, 16'hFFFF, 16'h0003, 16'h7FFF,
                  16'h000C, 16'h0010, 16'h0000, 16'hFFFC, 16'h7FFF,
                  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_last, frame_err, out_data}, '0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean 16x16 ramp frame, no stalls.
    push_ramp_exp();
    send_ramp(1'b0);
    wait_drain("ramp_drain");
    chk("ramp_frame_err", frame_err, 0);

    // Same frame with output stalls and input gaps.
    stall_en = 1'b1;
    push_ramp_exp();
    send_ramp(1'b1);
    wait_drain("stall_drain");
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_frame_err", frame_err, 0);

    // 5x3 frames, signed and unsigned, two frames back to back.
    send_small(0);
    send_small(0);
    repeat (3) @(posedge clk);
    #1;
    eb = '{33'h0_0008_FFFE, 33'h1_000D_0003, 33'h0_0008_FFFE, 33'h1_000D_0003};
    ec = '{33'h0_0008_FFFE, 33'h1_000D_FFFF, 33'h0_0008_FFFE, 33'h1_000D_FFFF};
    chk("small_b_count", got_b.size(), 4);
    chk("small_c_count", got_c.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_b.size()) chk($sformatf("small_signed_%0d", i), got_b[i], eb[i]);
      if (i < got_c.size()) chk($sformatf("small_unsigned_%0d", i), got_c[i], ec[i]);
    end
    chk("small_frame_err", {b_frame_err, c_frame_err}, 0);

`ifdef POOL2D_AVG_EN
    // Window 0 averaged, window 1 max.
    got_b.delete();
    got_c.delete();
    send_small(1);
    repeat (3) @(posedge clk);
    #1;
    chk("avg_b_count", got_b.size(), 2);
    chk("avg_c_count", got_c.size(), 2);
    if (got_b.size() == 2) begin
      chk("avg_signed_w0", got_b[0], 33'h0_0014_000A);
      chk("avg_signed_w1", got_b[1], 33'h1_000D_0003);
    end
    if (got_c.size() == 2) begin
      chk("avg_unsigned_w0", got_c[0], 33'h0_0014_000A);
      chk("avg_unsigned_w1", got_c[1], 33'h1_000D_FFFF);
    end
`endif

    // Early in_last at pixel 100: frame_err sets and stays set.
    scb_en = 1'b0;
    for (int i = 0; i <= 100; i++) send_px(ramp_px(i / 16, i % 16), i == 100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("frame_err_set", frame_err, 1);
    for (int i = 101; i < 121; i++) send_px(ramp_px(i / 16, i % 16), 1'b0, 1'b0);
    chk("frame_err_sticky", frame_err, 1);

    // Reset mid-frame, then a clean frame must pool correctly.
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {out_valid, out_last, frame_err, out_data}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    scb_en = 1'b1;
    @(posedge clk);
    #1;
    push_ramp_exp();
    send_ramp(1'b0);
    wait_drain("post_reset_drain");
    chk("post_reset_frame_err", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
